// File: rtl/ramp_gen_multi.sv
// Multi-channel test-pattern generator: NUM_CH interleaved ramp/fixed/walking-one streams
// tagged onto a FIFO write port. Define RAMP_GEN_HEADER_EN to prefix each run with a header word.

module ramp_gen_lane #(
    parameter int DATA_W = 7,
    parameter int STEP   = 1,
    parameter int CH     = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init,
    input  logic              adv,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fixed_value,
    output logic [DATA_W-1:0] sample,
    output logic              wrap
);
    localparam int              MOD    = 1 << DATA_W;
    localparam logic [DATA_W:0] STEP_X = (DATA_W+1)'(STEP);
    localparam logic [DATA_W-1:0] UP0   = DATA_W'((CH * STEP) % MOD);
    localparam logic [DATA_W-1:0] WALK0 = DATA_W'(1 << (CH % DATA_W));

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] rot;
    logic [DATA_W-1:0] init_val;
    logic [DATA_W-1:0] next_val;

    // The extra top bit of sum/diff is the carry/borrow that flags a wrap.
    assign sum  = {1'b0, sample} + STEP_X;
    assign diff = {1'b0, sample} - STEP_X;
    assign rot  = (sample << 1) | (sample >> (DATA_W - 1));

    always_comb begin
        init_val = UP0;
        next_val = sample;
        wrap     = 1'b0;
        case (mode)
            2'b00: begin
                init_val = UP0;
                next_val = sum[DATA_W-1:0];
                wrap     = sum[DATA_W];
            end
            2'b01: begin
                init_val = ~UP0;
                next_val = diff[DATA_W-1:0];
                wrap     = diff[DATA_W];
            end
            2'b10: begin
                init_val = fixed_value;
            end
            default: begin
                init_val = WALK0;
                next_val = rot;
                wrap     = sample[DATA_W-1];
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            sample <= '0;
        else if (init)
            sample <= init_val;
        else if (adv)
            sample <= next_val;
    end
endmodule

module ramp_gen_multi #(
    parameter int DATA_W = 7,
    parameter int NUM_CH = 4,
    parameter int STEP   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fixed_value,
    input  logic [15:0]       burst_len,
    input  logic              fifo_full,
    output logic [15:0]       data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              done,
    output logic [15:0]       stall_count
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  mode_q;
    logic [15:0] burst_q;
    logic [15:0] remaining;
    logic [CH_W-1:0] ptr;

    logic init;
    logic emit;
    logic emit_word;
    logic last_word;
    logic [1:0] lane_mode;
    logic [15:0] word;

    logic [NUM_CH-1:0][DATA_W-1:0] lane_sample;
    logic [NUM_CH-1:0]             lane_wrap;
    logic [NUM_CH-1:0]             lane_adv;
    logic [DATA_W-1:0]             cur_sample;
    logic                          cur_wrap;

    assign init      = (state == S_IDLE) && start;
    assign emit      = (state == S_RUN) && enable && !fifo_full;
    assign last_word = (burst_q != 16'd0) && (remaining == 16'd1);
    assign busy      = (state == S_RUN);
    // Lanes load from the live mode at start, then follow the latched copy.
    assign lane_mode = (state == S_IDLE) ? mode : mode_q;

`ifdef RAMP_GEN_HEADER_EN
    localparam logic [15:0] HDR = 16'hA5A0 | {13'd0, 3'(NUM_CH - 1)};
    logic hdr_pend;

    assign emit_word = emit && !hdr_pend;

    always_ff @(posedge clock) begin
        if (reset)
            hdr_pend <= 1'b0;
        else if (init)
            hdr_pend <= 1'b1;
        else if (emit)
            hdr_pend <= 1'b0;
    end
`else
    assign emit_word = emit;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_lane
            assign lane_adv[g] = emit_word && (ptr == CH_W'(g));
            ramp_gen_lane #(.DATA_W(DATA_W), .STEP(STEP), .CH(g)) u_lane (
                .clock       (clock),
                .reset       (reset),
                .init        (init),
                .adv         (lane_adv[g]),
                .mode        (lane_mode),
                .fixed_value (fixed_value),
                .sample      (lane_sample[g]),
                .wrap        (lane_wrap[g])
            );
        end
    endgenerate

    always_comb begin
        cur_sample = '0;
        cur_wrap   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ptr == CH_W'(c)) begin
                cur_sample = lane_sample[c];
                cur_wrap   = lane_wrap[c];
            end
        end
        word = {3'(ptr), cur_wrap, 12'(cur_sample)};
`ifdef RAMP_GEN_HEADER_EN
        if (hdr_pend)
            word = HDR;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            mode_q      <= 2'b00;
            burst_q     <= 16'd0;
            remaining   <= 16'd0;
            ptr         <= '0;
            data_out    <= 16'd0;
            data_valid  <= 1'b0;
            done        <= 1'b0;
            stall_count <= 16'd0;
        end else begin
            data_valid <= emit;
            done       <= (state == S_DONE);
            if (emit)
                data_out <= word;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_RUN;
                        mode_q      <= mode;
                        burst_q     <= burst_len;
                        remaining   <= burst_len;
                        ptr         <= '0;
                        stall_count <= 16'd0;
                    end
                end
                S_RUN: begin
                    if (enable && fifo_full && stall_count != 16'hFFFF)
                        stall_count <= stall_count + 16'd1;
                    if (emit_word) begin
                        ptr <= (ptr == CH_W'(NUM_CH - 1)) ? '0 : ptr + 1'b1;
                        if (burst_q != 16'd0)
                            remaining <= remaining - 16'd1;
                    end
                    if (stop || (emit_word && last_word))
                        state <= S_DONE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ramp_gen_multi.sv
// Randomized scoreboard bench for ramp_gen_multi (DATA_W=7, NUM_CH=4, STEP=1).
module tb_ramp_gen_multi;
    localparam int DW   = 7;
    localparam int NCH  = 4;
    localparam int STEP = 1;
    localparam int M    = 1 << DW;
`ifdef RAMP_GEN_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif
    localparam int HDR = 16'hA5A0 | (NCH - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0, start = 1'b0, stop = 1'b0, fifo_full = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [DW-1:0] fixed = '0;
    logic [15:0] burst = 16'd0;
    logic [15:0] data_out, stall_count;
    logic data_valid, busy, done;

    ramp_gen_multi #(.DATA_W(DW), .NUM_CH(NCH), .STEP(STEP)) dut (
        .clock(clk), .reset(rst), .enable(enable), .start(start), .stop(stop),
        .mode(mode), .fixed_value(fixed), .burst_len(burst), .fifo_full(fifo_full),
        .data_out(data_out), .data_valid(data_valid), .busy(busy), .done(done),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int sb[$];
    int obs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the run at transaction level and predicts each word.
    int m_st = 0;          // 0 idle, 1 running, 2 finishing
    int m_mode, m_burst, m_left, m_ptr;
    int m_val[NCH];        // ramp/fixed: sample value; walking-one: bit position
    bit m_hdr;
    int exp_stall = 0;
    bit exp_busy = 0, exp_done = 0;

    task automatic model_emit();
        int s, w;
        if (m_hdr) begin
            sb.push_back(HDR);
            m_hdr = 1'b0;
            return;
        end
        w = 0;
        case (m_mode)
            0: begin s = m_val[m_ptr]; w = (s + STEP >= M); m_val[m_ptr] = (s + STEP) % M; end
            1: begin s = m_val[m_ptr]; w = (s < STEP); m_val[m_ptr] = (s - STEP + M) % M; end
            2: s = m_val[m_ptr];
            default: begin s = 1 << m_val[m_ptr]; w = (m_val[m_ptr] == DW - 1);
                           m_val[m_ptr] = (m_val[m_ptr] + 1) % DW; end
        endcase
        sb.push_back((m_ptr << 13) | (w << 12) | s);
        m_ptr = (m_ptr + 1) % NCH;
        if (m_burst != 0) begin
            m_left--;
            if (m_left == 0) m_st = 2;
        end
    endtask

    always @(posedge clk) begin
        exp_done = (m_st == 2) && !rst;
        if (rst) begin
            m_st = 0;
            sb.delete();
            exp_stall = 0;
        end else if (m_st == 0) begin
            if (start) begin
                m_st = 1; m_mode = mode; m_burst = burst; m_left = burst; m_ptr = 0;
                exp_stall = 0; m_hdr = HDR_EN;
                for (int c = 0; c < NCH; c++)
                    case (mode)
                        0: m_val[c] = (c * STEP) % M;
                        1: m_val[c] = (M - 1) - (c * STEP) % M;
                        2: m_val[c] = fixed;
                        default: m_val[c] = c % DW;
                    endcase
            end
        end else if (m_st == 1) begin
            if (enable && fifo_full && exp_stall < 65535) exp_stall++;
            if (enable && !fifo_full) model_emit();
            if (stop) m_st = 2;
        end else begin
            m_st = 0;
        end
        exp_busy = (m_st == 1);
    end

    // Monitor: pops the scoreboard whenever the DUT strobes a word.
    always @(negedge clk) begin
        if (chk_en) begin
            if (data_valid) begin
                obs.push_back(data_out);
                if (sb.size() == 0) chk("unexpected_word", data_out, -1);
                else chk("data_out", data_out, sb.pop_front());
            end
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("stall_count", stall_count, exp_stall);
        end
    end

    task automatic pulse_start(input int md, input int fv, input int len);
        mode = 2'(md); fixed = DW'(fv); burst = 16'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    int tbl[$];
    int stop_at, len;
    bit seen;

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_data_out", data_out, 0);
        chk("reset_valid", data_valid, 0);
        rst = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // Directed: 4-channel ramp-up burst of 8 against the hand-written sequence.
        if (HDR_EN) tbl.push_back(HDR);
        tbl.push_back(16'h0000); tbl.push_back(16'h2001); tbl.push_back(16'h4002); tbl.push_back(16'h6003);
        tbl.push_back(16'h0001); tbl.push_back(16'h2002); tbl.push_back(16'h4003); tbl.push_back(16'h6004);
        obs.delete();
        pulse_start(0, 0, 8);
        wait_done(50);
        chk("burst8_count", obs.size(), tbl.size());
        for (int i = 0; i < tbl.size() && i < obs.size(); i++) chk("burst8_word", obs[i], tbl[i]);
        @(negedge clk);

        // Long ramp-up and ramp-down bursts cross the wrap point on every channel.
        pulse_start(0, 0, 520);
        wait_done(700);
        @(negedge clk);
        pulse_start(1, 0, 520);
        wait_done(700);
        @(negedge clk);

        // Backpressure held for five cycles mid-burst.
        pulse_start(0, 0, 40);
        repeat (8) @(negedge clk);
        fifo_full = 1'b1;
        repeat (5) @(negedge clk);
        chk("stall_hold", stall_count, 5);
        fifo_full = 1'b0;
        wait_done(100);
        @(negedge clk);

        // Continuous walking-one, ended by stop.
        pulse_start(3, 0, 0);
        repeat (30) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(5);
        chk("stop_busy", busy, 0);
        @(negedge clk);

        // Reset mid-burst, then a clean restart.
        pulse_start(1, 0, 50);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        obs.delete();
        pulse_start(1, 0, 6);
        wait_done(50);
        chk("restart_first", (obs.size() > 0) ? obs[0] : -1, HDR_EN ? HDR : 16'h007F);
        @(negedge clk);

        // Randomized runs: random mode, length, enable/backpressure, early stop, stray starts.
        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(0, 40);
            stop_at = (len == 0 || $urandom_range(0, 2) == 0) ? $urandom_range(2, 60) : 1000;
            pulse_start($urandom_range(0, 3), $urandom_range(0, M - 1), len);
            seen = 1'b0;
            for (int k = 0; k < 600; k++) begin
                if (done) begin seen = 1'b1; break; end
                enable    = ($urandom_range(0, 3) != 0);
                fifo_full = ($urandom_range(0, 3) == 0);
                stop      = (k == stop_at);
                start     = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
            start = 1'b0; stop = 1'b0; enable = 1'b1; fifo_full = 1'b0;
            if (!seen) chk("rand_done_timeout", 0, 1);
            if ($urandom_range(0, 1) == 1) begin
                stop = 1'b1;   // stop while idle must be ignored
                @(negedge clk);
                stop = 1'b0;
            end
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
